uplink_word_arbiter: RTL and testbench
======================================

# uplink_word_arbiter

Shares the single serial uplink lane (LVDS_OUT data bit) of the breakout board among several 12-bit word sources, such as digital-input events, I2C responses and link-status reports. Each source offers packets of 12-bit words through a valid/ready/last handshake. The block grants sources round-robin with per-packet locking and serializes the granted words MSB-first, one bit per clock. It fills every gap with the IDLE word 12'h100, so the host deserializer always sees continuous 12-bit framing.

## Interface
- N_SRC, 4: number of requesting sources (2..8).
- WORD_W, 12: word width; one word occupies WORD_W clocks on the lane.
- IDLE_WORD, 12'h100: filler/sync word sent whenever no source word is loaded.
- MAX_GAP, 4: consecutive idle fills tolerated inside a locked packet before the lock is aborted.

- clk  in  1  serializer bit clock; one lane bit per cycle.
- reset_n  in  1  asynchronous, active-low reset.
- src_valid  in  N_SRC  source i has a word on src_data slice i.
- src_last  in  N_SRC  word on slice i is the last word of its packet.
- src_data  in  N_SRC*WORD_W  word from source i at bits [i*WORD_W +: WORD_W].
- src_ready  out  N_SRC  one-hot pulse; the word from source i is consumed at this clock edge.
- ser_out  out  1  serial lane bit (MSB of the shift register).
- word_strobe  out  1  high during the first bit of every word, idle words included.
- grant_id  out  3  source currently locked (valid while locked=1).
- locked  out  1  a packet is in progress.
- abort_pulse  out  1  one-cycle pulse when a lock is dropped by the MAX_GAP rule.

## Operation
- bit_cnt counts 0..WORD_W-1 and wraps. The "load cycle" is the cycle with bit_cnt==WORD_W-1.
- Shift register shreg shifts left by one bit each non-load cycle. ser_out = shreg[WORD_W-1].
- On the load cycle, the next word is selected as follows:
  - **Locked, src_valid[grant_id]=1:** assert src_ready[grant_id] and load its data. If src_last is also set, clear locked and set rr_ptr = grant_id+1 (mod N_SRC). Clear gap_cnt.
  - **Locked, src_valid[grant_id]=0:** load IDLE_WORD and increment gap_cnt. If gap_cnt reaches MAX_GAP, clear locked, pulse abort_pulse, set rr_ptr = grant_id+1 and clear gap_cnt.
  - **Unlocked:** search src_valid starting at rr_ptr, wrapping, and take the first valid source g. Assert src_ready[g] and load its data.
    - If src_last[g]=0, set locked=1 and grant_id=g.
    - If src_last[g]=1 (single-word packet), set rr_ptr = g+1 and do not lock.
    - If no source is valid, load IDLE_WORD.
- src_ready is combinational: it is asserted only during the load cycle and is at most one-hot. Sources must hold data/last stable while valid until they see ready.
- src_valid changes outside the load cycle have no effect.
- Words from other sources never interleave inside a locked packet.

## Timing
- Reset values: bit_cnt=0, shreg=IDLE_WORD, ser_out=0, word_strobe=1, src_ready=0, locked=0, grant_id=0, rr_ptr=0, gap_cnt=0, abort_pulse=0.
- After reset, the first IDLE word is driven immediately. The first load cycle is cycle WORD_W-1.
- Latency: data accepted at the load-cycle edge appears as its MSB on ser_out in the next cycle, with word_strobe=1. The LSB appears WORD_W-1 cycles later.
- Worst-case wait for an unlocked request is one word period plus the remaining packets of other sources.
- Lane throughput is exactly one word per WORD_W clocks. There are never short or long frames.
- abort_pulse is registered and high for the single cycle following the aborting load edge.
- Reset asserted mid-word or mid-packet: all state returns to reset values asynchronously, ser_out drops to 0 at once and the partial word is lost. After reset_n rises, the lane restarts with a full IDLE word.

## Test plan
- **Idle lane:** no valid after reset -> ser_out repeats 000100000000 every 12 cycles, word_strobe every 12th cycle, src_ready never asserts.
- **Single word:** src_valid[1]=1, src_last[1]=1, data 12'h7F0 -> src_ready[1] pulses once in a load cycle; the next 12 bits are 011111110000; rr_ptr becomes 2; the lane returns to idle.
- **Round-robin:** all four sources send continuous single-word packets (data 12'hA00+i) -> grant order 0,1,2,3,0; each src_ready fires once per 4 words.
- **Packet lock:** source 2 sends a 3-word packet (12'hA0F, 12'hA10, 12'hFFF with last), source 0 valid throughout -> three consecutive source-2 words, then source 0; locked=1 only during the source-2 packet.
- **Gap and abort:** source 3 sends one non-last word then drops valid -> 4 IDLE words, abort_pulse on the 4th, locked=0, next grant starts search at source 0.
- **Reset mid-word:** reset_n low at bit 5 of 12'hFFF -> ser_out=0 immediately; after release, 12 idle bits precede any granted word.

Source files
------------

// File: rtl/uplink_word_arbiter_if.sv
// rtl/uplink_word_arbiter_if.sv - source word handshake bundle for the uplink lane arbiter
interface uplink_word_arbiter_if #(
  parameter int N_SRC  = 4,
  parameter int WORD_W = 12
);
  logic [N_SRC-1:0]        src_valid;
  logic [N_SRC-1:0]        src_last;
  logic [N_SRC*WORD_W-1:0] src_data;
  logic [N_SRC-1:0]        src_ready;

  modport master (output src_valid, src_last, src_data, input src_ready);
  modport slave  (input src_valid, src_last, src_data, output src_ready);
endinterface

// File: rtl/uplink_word_arbiter.sv
// rtl/uplink_word_arbiter.sv - round-robin packet arbiter serializing 12-bit words onto one lane
module uplink_word_arbiter #(
  parameter int                N_SRC     = 4,
  parameter int                WORD_W    = 12,
  parameter logic [WORD_W-1:0] IDLE_WORD = 12'h100,
  parameter int                MAX_GAP   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  uplink_word_arbiter_if.slave src,
  output logic                 ser_out,
  output logic                 word_strobe,
  output logic [2:0]           grant_id,
  output logic                 locked,
  output logic                 abort_pulse
);

  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CNT_W = $clog2(WORD_W);
  localparam int GAP_W = $clog2(MAX_GAP + 1);

  logic [CNT_W-1:0]   bit_cnt;
  logic [WORD_W-1:0]  shreg;
  logic [SRC_W-1:0]   grant;
  logic [SRC_W-1:0]   rr_ptr;
  logic [GAP_W-1:0]   gap_cnt;

  logic               load_cycle;
  logic               found;
  logic [SRC_W-1:0]   pick;
  logic [SRC_W-1:0]   sel;
  logic [WORD_W-1:0]  sel_word;
  logic [WORD_W-1:0]  next_word;
  logic [2*N_SRC-1:0] rot;

  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] i);
    if (int'(i) == N_SRC - 1) return '0;
    return i + SRC_W'(1);
  endfunction

  assign load_cycle  = (bit_cnt == CNT_W'(WORD_W - 1));
  assign ser_out     = shreg[WORD_W-1];
  assign word_strobe = (bit_cnt == '0);
  assign grant_id    = 3'(grant);

  // Rotate valids so bit 0 is rr_ptr; the lowest set bit is the next grant.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    rot   = {src.src_valid, src.src_valid} >> rr_ptr;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        pick  = SRC_W'((int'(rr_ptr) + k) % N_SRC);
      end
    end
  end

  always_comb begin
    sel      = locked ? grant : pick;
    sel_word = IDLE_WORD;
    for (int i = 0; i < N_SRC; i++) begin
      if (SRC_W'(i) == sel) sel_word = src.src_data[i*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    src.src_ready = '0;
    next_word     = IDLE_WORD;
    if (load_cycle) begin
      if (locked) begin
        if (src.src_valid[grant]) begin
          src.src_ready[grant] = 1'b1;
          next_word            = sel_word;
        end
      end else if (found) begin
        src.src_ready[pick] = 1'b1;
        next_word           = sel_word;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt     <= '0;
      shreg       <= IDLE_WORD;
      grant       <= '0;
      rr_ptr      <= '0;
      gap_cnt     <= '0;
      locked      <= 1'b0;
      abort_pulse <= 1'b0;
    end else begin
      abort_pulse <= 1'b0;
      if (!load_cycle) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        shreg   <= {shreg[WORD_W-2:0], 1'b0};
      end else begin
        bit_cnt <= '0;
        shreg   <= next_word;
        if (locked) begin
          if (src.src_valid[grant]) begin
            gap_cnt <= '0;
            if (src.src_last[grant]) begin
              locked <= 1'b0;
              rr_ptr <= wrap_inc(grant);
            end
          end else if (gap_cnt == GAP_W'(MAX_GAP - 1)) begin
            // Source stalled too long inside its packet: release the lane.
            locked      <= 1'b0;
            abort_pulse <= 1'b1;
            rr_ptr      <= wrap_inc(grant);
            gap_cnt     <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end else if (found) begin
          if (src.src_last[pick]) begin
            rr_ptr <= wrap_inc(pick);
          end else begin
            locked <= 1'b1;
            grant  <= pick;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uplink_word_arbiter.sv
// tb/tb_uplink_word_arbiter.sv - scoreboard bench for uplink_word_arbiter
module tb_uplink_word_arbiter;

  localparam logic [11:0] IDLE = 12'h100;

  typedef struct {
    logic [11:0] word;
    logic        lk;
    logic        ab;
    int          gid;
    int          rdy;
  } frame_t;

  logic       clk;
  logic       reset_n;
  logic       ser_out;
  logic       word_strobe;
  logic [2:0] grant_id;
  logic       locked;
  logic       abort_pulse;

  int          checks;
  int          errors;
  int          ph;
  logic [11:0] bits;
  frame_t      exp_q[$];
  logic [12:0] sq[4][$];

  uplink_word_arbiter_if #(.N_SRC(4), .WORD_W(12)) src_if ();

  uplink_word_arbiter #(
    .N_SRC(4), .WORD_W(12), .IDLE_WORD(12'h100), .MAX_GAP(4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .src         (src_if.slave),
    .ser_out     (ser_out),
    .word_strobe (word_strobe),
    .grant_id    (grant_id),
    .locked      (locked),
    .abort_pulse (abort_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void exp_frame(logic [11:0] w, logic lk, logic ab, int gid, int rdy);
    frame_t f;
    f.word = w;
    f.lk   = lk;
    f.ab   = ab;
    f.gid  = gid;
    f.rdy  = rdy;
    exp_q.push_back(f);
  endfunction

  // One lane cycle, entered and left #1 after a rising edge; ph tracks the expected bit position.
  task automatic step();
    frame_t     f;
    logic [3:0] expv;
    bits = {bits[10:0], ser_out};
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: ph=%0d has no expected frame", ph);
    end else begin
      f = exp_q[0];
      if (ph == 0) begin
        checks++;
        if (word_strobe !== 1'b1) begin errors++; $display("FAIL strobe_first_bit: got %b want 1", word_strobe); end
        checks++;
        if (locked !== f.lk) begin errors++; $display("FAIL locked: got %b want %b (word %h)", locked, f.lk, f.word); end
        checks++;
        if (abort_pulse !== f.ab) begin errors++; $display("FAIL abort_pulse: got %b want %b (word %h)", abort_pulse, f.ab, f.word); end
        if (f.lk) begin
          checks++;
          if (grant_id !== 3'(f.gid)) begin errors++; $display("FAIL grant_id: got %0d want %0d", grant_id, f.gid); end
        end
      end else begin
        checks++;
        if (word_strobe !== 1'b0) begin errors++; $display("FAIL strobe_mid_word: got %b want 0 at ph %0d", word_strobe, ph); end
        if (ph == 1) begin
          checks++;
          if (abort_pulse !== 1'b0) begin errors++; $display("FAIL abort_width: got %b want 0", abort_pulse); end
        end
      end
      if (ph == 11) begin
        for (int i = 0; i < 4; i++) begin
          src_if.src_valid[i] = (sq[i].size() > 0);
          src_if.src_last[i]  = (sq[i].size() > 0) ? sq[i][0][12] : 1'b0;
          src_if.src_data[i*12 +: 12] = (sq[i].size() > 0) ? sq[i][0][11:0] : 12'h000;
        end
        #1;
        checks++;
        if (bits !== f.word) begin errors++; $display("FAIL lane_word: got %h want %h", bits, f.word); end
        expv = '0;
        if (f.rdy >= 0) expv[f.rdy] = 1'b1;
        checks++;
        if (src_if.src_ready !== expv) begin errors++; $display("FAIL load_ready: got %b want %b", src_if.src_ready, expv); end
        for (int i = 0; i < 4; i++) begin
          if (src_if.src_ready[i] && sq[i].size() > 0) void'(sq[i].pop_front());
        end
        void'(exp_q.pop_front());
      end else begin
        checks++;
        if (src_if.src_ready !== 4'b0000) begin errors++; $display("FAIL ready_outside_load: got %b at ph %0d", src_if.src_ready, ph); end
      end
    end
    @(posedge clk);
    #1;
    ph = (ph == 11) ? 0 : ph + 1;
  endtask

  task automatic run_frames(int n);
    for (int c = 0; c < n * 12; c++) step();
  endtask

  task automatic check_reset_state(string tag);
    checks++;
    if (ser_out !== 1'b0) begin errors++; $display("FAIL %s_ser_out: got %b want 0", tag, ser_out); end
    checks++;
    if (word_strobe !== 1'b1) begin errors++; $display("FAIL %s_strobe: got %b want 1", tag, word_strobe); end
    checks++;
    if (src_if.src_ready !== 4'b0000) begin errors++; $display("FAIL %s_ready: got %b want 0000", tag, src_if.src_ready); end
    checks++;
    if (locked !== 1'b0 || grant_id !== 3'd0 || abort_pulse !== 1'b0) begin
      errors++;
      $display("FAIL %s_ctrl: got locked=%b grant=%0d abort=%b want 0/0/0", tag, locked, grant_id, abort_pulse);
    end
  endtask

  task automatic test_reset();
    check_reset_state("reset");
    reset_n = 1'b1;
    ph = 0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) exp_frame(IDLE, 1'b0, 1'b0, 0, -1);
    run_frames(3);
  endtask

  task automatic test_round_robin();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) sq[i].push_back({1'b1, 12'hA00 + 12'(i)});
    exp_frame(IDLE, 1'b0, 1'b0, 0, 0);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++)
        exp_frame(12'hA00 + 12'(i), 1'b0, 1'b0, 0, (r == 1 && i == 3) ? -1 : (i + 1) % 4);
    exp_frame(IDLE, 1'b0, 1'b0, 0, -1);
    run_frames(10);
  endtask

  task automatic test_single_word();
    sq[1].push_back({1'b1, 12'h7F0});
    exp_frame(IDLE,   1'b0, 1'b0, 0, 1);
    exp_frame(12'h7F0, 1'b0, 1'b0, 0, -1);
    exp_frame(IDLE,   1'b0, 1'b0, 0, -1);
    run_frames(3);
    for (int i = 0; i < 3; i++) sq[i].push_back({1'b1, 12'h5A0 + 12'(i)});
    exp_frame(IDLE,    1'b0, 1'b0, 0, 2);
    exp_frame(12'h5A2, 1'b0, 1'b0, 0, 0);
    exp_frame(12'h5A0, 1'b0, 1'b0, 0, 1);
    exp_frame(12'h5A1, 1'b0, 1'b0, 0, -1);
    run_frames(4);
  endtask

  task automatic test_packet_lock();
    sq[2].push_back({1'b0, 12'hA0F});
    sq[2].push_back({1'b0, 12'hA10});
    sq[2].push_back({1'b1, 12'hFFF});
    sq[0].push_back({1'b1, 12'h0C1});
    sq[0].push_back({1'b1, 12'h0C2});
    exp_frame(IDLE,    1'b0, 1'b0, 0, 2);
    exp_frame(12'hA0F, 1'b1, 1'b0, 2, 2);
    exp_frame(12'hA10, 1'b1, 1'b0, 2, 2);
    exp_frame(12'hFFF, 1'b0, 1'b0, 0, 0);
    exp_frame(12'h0C1, 1'b0, 1'b0, 0, 0);
    exp_frame(12'h0C2, 1'b0, 1'b0, 0, -1);
    exp_frame(IDLE,    1'b0, 1'b0, 0, -1);
    run_frames(7);
  endtask

  task automatic test_gap_abort();
    sq[3].push_back({1'b0, 12'h3A5});
    exp_frame(IDLE,    1'b0, 1'b0, 0, 3);
    exp_frame(12'h3A5, 1'b1, 1'b0, 3, -1);
    for (int i = 0; i < 3; i++) exp_frame(IDLE, 1'b1, 1'b0, 3, -1);
    run_frames(5);
    sq[0].push_back({1'b1, 12'hB00});
    sq[1].push_back({1'b1, 12'hB01});
    sq[3].push_back({1'b1, 12'hB03});
    exp_frame(IDLE,    1'b0, 1'b1, 0, 0);
    exp_frame(12'hB00, 1'b0, 1'b0, 0, 1);
    exp_frame(12'hB01, 1'b0, 1'b0, 0, 3);
    exp_frame(12'hB03, 1'b0, 1'b0, 0, -1);
    run_frames(4);
  endtask

  task automatic test_reset_mid_word();
    sq[2].push_back({1'b1, 12'hFFF});
    exp_frame(IDLE,    1'b0, 1'b0, 0, 2);
    exp_frame(12'hFFF, 1'b0, 1'b0, 0, -1);
    run_frames(1);
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (ser_out !== 1'b1) begin errors++; $display("FAIL pre_reset_bit5: got %b want 1", ser_out); end
    reset_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    ph = 0;
    sq[0].push_back({1'b1, 12'h9C3});
    sq[3].push_back({1'b1, 12'h3C9});
    exp_frame(IDLE,    1'b0, 1'b0, 0, 0);
    exp_frame(12'h9C3, 1'b0, 1'b0, 0, 3);
    exp_frame(12'h3C9, 1'b0, 1'b0, 0, -1);
    exp_frame(IDLE,    1'b0, 1'b0, 0, -1);
    run_frames(4);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ph = 0;
    bits = '0;
    reset_n = 1'b0;
    src_if.src_valid = '0;
    src_if.src_last  = '0;
    src_if.src_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_idle();
    test_round_robin();
    test_single_word();
    test_packet_lock();
    test_gap_abort();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
